// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM receive path.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } tdm_state_e;

  // Consecutive frames without sync at slot 0 before lock is dropped.
  localparam int MISS_LIMIT = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/demux_dec.sv
// SLOT_W-to-N_CH one-hot decoder with enable; selects the shadow slot to write.
module demux_dec #(
  parameter int N_CH   = 8,
  parameter int SLOT_W = 3
) (
  input  logic [SLOT_W-1:0] sel,
  input  logic              en,
  output logic [N_CH-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: rebuilds N_CH parallel channels from one slotted lane.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter  int N_CH   = 8,
  parameter  int W      = 1,
  localparam int SLOT_W = clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [W-1:0]        din,
  input  logic                din_valid,
  input  logic                frame_sync,
  output logic [N_CH*W-1:0]   ch_out,
  output logic                frame_valid,
  output logic [SLOT_W-1:0]   slot_idx,
  output logic                locked,
  output logic                sync_err
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_CH - 1);
  localparam logic [1:0]        MISS_LAST = 2'(MISS_LIMIT - 1);

  tdm_state_e              state, state_nxt;
  logic [SLOT_W-1:0]       slot_nxt;
  logic [1:0]              miss_cnt, miss_nxt;
  logic [N_CH-1:0][W-1:0]  shadow;
  logic [N_CH-1:0]         wr_onehot;
  logic [SLOT_W-1:0]       wr_sel;
  logic                    wr_en;
  logic                    frame_done;
  logic                    realign;

  // Every decision is qualified by din_valid, so idle cycles leave all state alone.
  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot_idx;
    miss_nxt   = miss_cnt;
    wr_en      = 1'b0;
    wr_sel     = slot_idx;
    frame_done = 1'b0;
    realign    = 1'b0;
    if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (frame_sync) begin
            wr_en     = 1'b1;
            wr_sel    = '0;
            slot_nxt  = SLOT_W'(1);
            miss_nxt  = '0;
            state_nxt = LOCK;
          end
        end
        LOCK: begin
          if (frame_sync && (slot_idx != '0)) begin
            realign  = 1'b1;
            wr_en    = 1'b1;
            wr_sel   = '0;
            slot_nxt = SLOT_W'(1);
          end else if (!frame_sync && (slot_idx == '0) && (miss_cnt == MISS_LAST)) begin
            state_nxt = HUNT;
            slot_nxt  = '0;
            miss_nxt  = '0;
          end else begin
            wr_en      = 1'b1;
            slot_nxt   = slot_idx + SLOT_W'(1);
            frame_done = (slot_idx == LAST_SLOT);
            if (slot_idx == '0) miss_nxt = frame_sync ? 2'd0 : miss_cnt + 2'd1;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  demux_dec #(
    .N_CH   (N_CH),
    .SLOT_W (SLOT_W)
  ) u_dec (
    .sel    (wr_sel),
    .en     (wr_en),
    .onehot (wr_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      slot_idx <= '0;
      miss_cnt <= '0;
    end else begin
      state    <= state_nxt;
      slot_idx <= slot_nxt;
      miss_cnt <= miss_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (wr_onehot[k]) shadow[k] <= din;
      end
    end
  end

  // The last slot bypasses the shadow so the whole frame lands on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_out      <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      sync_err    <= realign;
      if (frame_done) ch_out <= {din, shadow[N_CH-2:0]};
    end
  end

  assign locked = (state == LOCK);

endmodule
